// File: rtl/accel_poll_master.sv
// Avalon-MM polling master: reads the accelerometer X/Y/Z registers once per
// poll period and publishes each coherent triple with a one-cycle valid strobe.
module accel_poll_master #(
    parameter int unsigned POLL_CYCLES    = 50000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        clear_err,
    output logic [1:0]  avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic [15:0] sample_x,
    output logic [15:0] sample_y,
    output logic [15:0] sample_z,
    output logic        sample_valid,
    output logic [15:0] sample_count,
    output logic        timeout_err,
    output logic        overrun_err
);

    localparam logic [23:0] TIMER_RELOAD = 24'(POLL_CYCLES - 1);
    localparam logic [15:0] STALL_LIMIT  = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, RD_X, RD_Y, RD_Z, DONE} state_t;

    state_t      state;
    logic [23:0] timer;
    logic [15:0] stall_count;
    logic [15:0] shadow_x;
    logic [15:0] shadow_y;
    logic        tick;
    logic        in_read;
    logic        abort;
    logic        unused_readdata_hi;

    assign tick    = enable && (timer == '0);
    assign in_read = (state == RD_X) || (state == RD_Y) || (state == RD_Z);
    // Abort on the TIMEOUT_CYCLES-th consecutive stall cycle of a single read.
    assign abort   = in_read && avm_waitrequest && (stall_count == STALL_LIMIT);

    assign unused_readdata_hi = ^avm_readdata[31:16];

    // Start-to-start poll timer; frozen at its reload value while disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= TIMER_RELOAD;
        end else if (!enable || tick) begin
            timer <= TIMER_RELOAD;
        end else begin
            timer <= timer - 24'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (clear_err) begin
                timeout_err <= 1'b0;
                overrun_err <= 1'b0;
            end
            // NOTE: the later non-blocking assignment wins, so an error event in
            // the same cycle as clear_err leaves the flag set.
            if (abort) begin
                timeout_err <= 1'b1;
            end
            if (tick && (state != IDLE)) begin
                overrun_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            avm_read     <= 1'b0;
            avm_address  <= 2'd0;
            stall_count  <= '0;
            shadow_x     <= '0;
            shadow_y     <= '0;
            sample_x     <= '0;
            sample_y     <= '0;
            sample_z     <= '0;
            sample_valid <= 1'b0;
            sample_count <= '0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        state       <= RD_X;
                        avm_read    <= 1'b1;
                        avm_address <= 2'd0;
                        stall_count <= '0;
                    end
                end

                RD_X, RD_Y, RD_Z: begin
                    if (avm_waitrequest) begin
                        if (abort) begin
                            state       <= IDLE;
                            avm_read    <= 1'b0;
                            avm_address <= 2'd0;
                            stall_count <= '0;
                        end else begin
                            stall_count <= stall_count + 16'd1;
                        end
                    end else begin
                        stall_count <= '0;
                        if (state == RD_X) begin
                            shadow_x    <= avm_readdata[15:0];
                            avm_address <= 2'd1;
                            state       <= RD_Y;
                        end else if (state == RD_Y) begin
                            shadow_y    <= avm_readdata[15:0];
                            avm_address <= 2'd2;
                            state       <= RD_Z;
                        end else begin
                            // Publish all three axes on the same edge.
                            sample_x     <= shadow_x;
                            sample_y     <= shadow_y;
                            sample_z     <= avm_readdata[15:0];
                            sample_valid <= 1'b1;
                            sample_count <= sample_count + 16'd1;
                            avm_read     <= 1'b0;
                            avm_address  <= 2'd0;
                            state        <= DONE;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state    <= IDLE;
                    avm_read <= 1'b0;
                end
            endcase
        end
    end

endmodule
